// File: rtl/rip_common_pkg.sv
// Shared RIP definitions: the datapath width, the JAL opcode and a J-type immediate decoder.
// Package name: rip_common. No ports.
package rip_common;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [6:0]  OPCODE_JAL = 7'b1101111;

  // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} in inst[31:12], sign-extended.
  function automatic logic [DATA_WIDTH-1:0] j_imm(input logic [DATA_WIDTH-1:0] inst);
    j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rip_fetch_predecode.sv
// rip_fetch_predecode: looks at the instruction sitting in decode. It flags a JAL and computes
// the JAL target.
// Ports:
//   inst    - instruction word in decode
//   inst_pc - byte address of inst
//   is_jal  - the opcode is JAL
//   target  - inst_pc + sign-extended J-immediate, modulo 2^32
// Instantiated by rip_fetch only when RIP_FETCH_JAL_PREDICT_EN is defined.
module rip_fetch_predecode
  import rip_common::*;
(
  input  logic [DATA_WIDTH-1:0] inst,
  input  logic [DATA_WIDTH-1:0] inst_pc,
  output logic                  is_jal,
  output logic [DATA_WIDTH-1:0] target
);

  // rd (inst[11:7]) plays no part in prediction.
  logic unused_rd;
  assign unused_rd = ^inst[11:7];

  always_comb begin
    is_jal = (inst[6:0] == OPCODE_JAL);
    target = inst_pc + j_imm(inst);
  end

endmodule

// File: rtl/rip_fetch.sv
// rip_fetch: the instruction fetch stage. It keeps a sequential PC and a registered decode slot.
// Instruction memory is synchronous, so the word fetched at pc shows up on if_dout one cycle
// later, and it is aligned with inst_pc_q.
// Parameters:
//   RESET_PC       - first fetch address after reset
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   stall          - hazard stall; holds fetch and the decode slot
//   redirect_valid - a resolved taken branch/jump; flushes decode and refetches at redirect_pc
//   redirect_pc    - redirect target byte address
//   pc, if_ready   - fetch address and read enable to instruction memory
//   if_dout        - instruction word returned by memory
//   id_inst, id_pc, id_valid, id_pred_taken - decode-side instruction, address, valid, prediction
// Optional macro RIP_FETCH_JAL_PREDICT_EN: JALs in decode steer fetch to their target.
module rip_fetch
  import rip_common::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  if_ready,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic                  id_valid,
  output logic                  id_pred_taken
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] inst_pc_q;
  logic                  inst_valid_q;

  logic                  pred_jal;
  logic [DATA_WIDTH-1:0] pred_target;
  logic                  pred_take;
  logic                  steer;
  logic [DATA_WIDTH-1:0] fetch_addr;

`ifdef RIP_FETCH_JAL_PREDICT_EN
  rip_fetch_predecode u_predecode (
    .inst    (if_dout),
    .inst_pc (inst_pc_q),
    .is_jal  (pred_jal),
    .target  (pred_target)
  );
`else
  assign pred_jal    = 1'b0;
  assign pred_target = '0;
`endif

  always_comb begin
    // rst is included so that a reset landing on a valid slot squashes decode at once.
    id_valid      = inst_valid_q & ~redirect_valid & ~rst;
    id_pc         = inst_pc_q;
    id_inst       = if_dout;
    id_pred_taken = id_valid & pred_jal;
    // id_valid already excludes a redirect, so an external redirect wins over the prediction.
    pred_take     = id_pred_taken & ~stall;
    steer         = redirect_valid | pred_take;

    fetch_addr = pc_q;
    if (redirect_valid) begin
      fetch_addr = redirect_pc;
    end else if (pred_take) begin
      fetch_addr = pred_target;
    end
    fetch_addr[1:0] = 2'b00;

    pc       = fetch_addr;
    if_ready = ~rst & (~stall | redirect_valid);
  end

  // Every cycle that reads memory (advance or steer) moves the fetched address into decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else if (steer || !stall) begin
      pc_q         <= fetch_addr + DATA_WIDTH'(4);
      inst_pc_q    <= fetch_addr;
      inst_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rip_fetch.sv
// Directed self-checking bench for rip_fetch. dut uses RESET_PC = 0 and is attached to a small
// synchronous instruction memory. dut_w uses RESET_PC = FFFF_FFF8 and shows the address wrap.
module tb_rip_fetch;
  import rip_common::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        if_ready;
  logic [31:0] if_dout;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        id_pred_taken;

  logic        w_stall = 1'b0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic [31:0] w_pc;
  logic        w_if_ready;
  logic [31:0] w_if_dout = 32'h0;
  logic [31:0] w_id_inst;
  logic [31:0] w_id_pc;
  logic        w_id_valid;
  logic        w_id_pred_taken;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rip_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .if_ready       (if_ready),
    .if_dout        (if_dout),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_valid       (id_valid),
    .id_pred_taken  (id_pred_taken)
  );

  rip_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .stall          (w_stall),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .pc             (w_pc),
    .if_ready       (w_if_ready),
    .if_dout        (w_if_dout),
    .id_inst        (w_id_inst),
    .id_pc          (w_id_pc),
    .id_valid       (w_id_valid),
    .id_pred_taken  (w_id_pred_taken)
  );

  // Memory image: address 0x20 holds "jal x0, +16"; every other word is an OP-IMM tagged with
  // its own address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h20) imem = 32'h0100_006F;
    else             imem = {a[24:0], 7'b0010011};
  endfunction

  always @(posedge clk) if (if_ready) if_dout <= imem(pc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);

    // Reset release
    rst = 1'b0; #1;
    check("rel_pc0", pc, 32'h0);
    check("rel_valid0", 32'(id_valid), 32'd0);
    check("rel_if_ready", 32'(if_ready), 32'd1);
    check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    tick();
    check("rel_pc1", pc, 32'h4);
    check("rel_valid1", 32'(id_valid), 32'd1);
    check("rel_id_pc0", id_pc, 32'h0);
    check("rel_id_inst0", id_inst, imem(32'h0));
    check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    check("pred_none", 32'(id_pred_taken), 32'd0);
    tick();
    check("rel_pc2", pc, 32'h8);
    check("rel_id_pc1", id_pc, 32'h4);
    check("wrap_pc2", w_pc, 32'h0000_0000);
    check("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
    tick();

    // Three-cycle stall with id_pc = 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_if_ready", 32'(if_ready), 32'd0);
      check("stall_pc", pc, 32'hC);
      check("stall_id_pc", id_pc, 32'h8);
      check("stall_id_inst", id_inst, imem(32'h8));
      tick();
    end
    stall = 1'b0; #1;
    check("unstall_id_pc", id_pc, 32'h8);
    check("unstall_if_ready", 32'(if_ready), 32'd1);
    tick();
    check("post_stall_id_pc", id_pc, 32'hC);
    check("post_stall_pc", pc, 32'h10);

    // A redirect under stall wins over the stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    check("redir_pc", pc, 32'h100);
    check("redir_id_valid", 32'(id_valid), 32'd0);
    check("redir_if_ready", 32'(if_ready), 32'd1);
    tick();
    stall = 1'b0; redirect_valid = 1'b0; #1;
    check("redir_id_pc", id_pc, 32'h100);
    check("redir_valid_next", 32'(id_valid), 32'd1);
    check("redir_id_inst", id_inst, imem(32'h100));
    check("redir_next_pc", pc, 32'h104);
    tick();

    // JAL +16 at 0x20
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0; #1;
    check("jal_id_pc", id_pc, 32'h20);
    check("jal_id_inst", id_inst, 32'h0100_006F);
`ifdef RIP_FETCH_JAL_PREDICT_EN
    check("jal_pred", 32'(id_pred_taken), 32'd1);
    check("jal_pc", pc, 32'h30);
    tick();
    check("jal_next_id_pc", id_pc, 32'h30);
`else
    check("jal_pred", 32'(id_pred_taken), 32'd0);
    check("jal_pc", pc, 32'h24);
    tick();
    check("jal_next_id_pc", id_pc, 32'h24);
`endif
    check("jal_next_pred", 32'(id_pred_taken), 32'd0);
    check("jal_next_valid", 32'(id_valid), 32'd1);

    // Reset asserted together with a redirect
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    check("rstredir_if_ready", 32'(if_ready), 32'd0);
    check("rstredir_id_valid", 32'(id_valid), 32'd0);
    tick();
    rst = 1'b0; redirect_valid = 1'b0; #1;
    check("rstredir_pc", pc, 32'h0);
    check("rstredir_valid0", 32'(id_valid), 32'd0);
    tick();
    check("rstredir_id_pc", id_pc, 32'h0);
    check("rstredir_valid1", 32'(id_valid), 32'd1);

    // Reset raised mid-stall squashes decode immediately
    stall = 1'b1; rst = 1'b1; #1;
    check("rststall_id_valid", 32'(id_valid), 32'd0);
    check("rststall_if_ready", 32'(if_ready), 32'd0);
    tick();
    rst = 1'b0; stall = 1'b0; #1;
    check("rststall_pc", pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rip_fetch.md
RIP_FETCH -- requirements
Module: rip_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port stall, input, 1: hazard-unit stall; hold fetch and decode-side outputs.
REQ-005 SHALL have port redirect_valid, input, 1: branch/jump resolved taken; flush and refetch.
REQ-006 SHALL have port redirect_pc, input, DATA_WIDTH: redirect target byte address.
REQ-007 SHALL have port pc, output, DATA_WIDTH: fetch byte address presented to instruction memory.
REQ-008 SHALL have port if_ready, output, 1: instruction-memory read enable.
REQ-009 SHALL have port if_dout, input, DATA_WIDTH: instruction word, valid one cycle after an if_ready-high read.
REQ-010 SHALL have port id_inst, output, DATA_WIDTH: instruction to decode; equals if_dout.
REQ-011 SHALL have port id_pc, output, DATA_WIDTH: byte address of id_inst.
REQ-012 SHALL have port id_valid, output, 1: id_inst/id_pc hold a correct-path instruction.
REQ-013 SHALL have port id_pred_taken, output, 1: id_inst was predicted taken by fetch.

Function
REQ-014 SHALL hold registers pc_q (next sequential fetch address), inst_pc_q and inst_valid_q.
REQ-015 SHALL drive pc = redirect target when a redirect applies this cycle, else pc_q; bits [1:0] forced to 2'b00.
REQ-016 SHALL drive if_ready = ~rst & (~stall | redirect_valid).
REQ-017 SHALL drive id_pc = inst_pc_q and id_valid = inst_valid_q & ~redirect_valid.
REQ-018 SHALL on an advance cycle (~stall, no redirect) update pc_q <= pc_q+4, inst_pc_q <= pc_q, inst_valid_q <= 1.
REQ-019 SHALL on stall without redirect hold pc_q, inst_pc_q and inst_valid_q; if_dout stays constant because if_ready is low.
REQ-020 SHALL on redirect_valid, which has priority over stall, update pc_q <= target+4, inst_pc_q <= target, inst_valid_q <= 1.
REQ-021 SHALL give a redirect a penalty of exactly one squashed decode slot: id_valid is low in the redirect cycle and the target is valid in decode the next cycle.
REQ-022 SHALL compute pc_q+4 and target+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.
REQ-023 SHALL keep id_pred_taken at 0 when no prediction applies.

Reset
REQ-024 SHALL while rst is high set pc_q <= RESET_PC, inst_pc_q <= 0, inst_valid_q <= 0, and drive if_ready = 0 and id_valid = 0.
REQ-025 SHALL give rst priority over redirect_valid and stall, including reset asserted mid-stall or mid-redirect.
REQ-026 SHALL in the first cycle after rst deasserts fetch RESET_PC with id_valid = 0; RESET_PC is valid in decode the following cycle.

Configuration
REQ-027 SHALL, with RIP_FETCH_JAL_PREDICT_EN defined, on an advance cycle with id_valid = 1 and id_inst opcode = JAL, redirect pc to id_pc + J-immediate (sign-extended).
REQ-028 SHALL, with RIP_FETCH_JAL_PREDICT_EN defined, on that predicted-taken cycle update pc_q <= target+4, inst_pc_q <= target, inst_valid_q <= 1.
REQ-029 SHALL, with RIP_FETCH_JAL_PREDICT_EN defined, drive id_pred_taken = id_valid & JAL, give an external redirect priority, and take no predict action under stall.
REQ-030 SHALL, without RIP_FETCH_JAL_PREDICT_EN, tie id_pred_taken to 0 and follow a JAL sequentially.

Structure
REQ-031 SHALL take DATA_WIDTH, OPCODE_JAL (7'b1101111) and a J-immediate extraction function from the shared rip_common package.
REQ-032 SHALL place JAL detection and target generation in sub-module rip_fetch_predecode, instantiated only under RIP_FETCH_JAL_PREDICT_EN.

Verification
REQ-033 SHALL cover reset release with RESET_PC = 0: pc = 0, 4, 8 on consecutive cycles; id_valid rises one cycle later with id_pc = 0, then 4.
REQ-034 SHALL cover a 3-cycle stall while id_pc = 8: if_ready = 0, and pc, id_pc and id_inst are constant for 3 cycles; id_pc = 12 the cycle after release.
REQ-035 SHALL cover redirect_valid with redirect_pc = 32'h100 while stall = 1: pc = 32'h100 and id_valid = 0 that cycle; next cycle id_pc = 32'h100 and id_valid = 1.
REQ-036 SHALL cover wrap with RESET_PC = 32'hFFFF_FFF8: fetch order is FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 SHALL cover, with RIP_FETCH_JAL_PREDICT_EN, JAL +16 at id_pc = 32'h20: id_pred_taken = 1, pc = 32'h30, next id_pc = 32'h30; without the macro, next id_pc = 32'h24.
REQ-038 SHALL cover rst asserted the same cycle as redirect_valid to 32'h200: the next fetch is RESET_PC and id_valid = 0.
